// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   // EX side drives requests and observes HI/LO and busy
   modport master (
      output start, op, rs_data, rt_data,
      input  busy, hi, lo
   );

   // Unit side accepts requests and owns HI/LO and busy
   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning the architectural HI/LO registers.
// The 64-bit result is computed at accept time and held in a pending register;
// HI/LO are only updated once the fixed busy window has elapsed.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam int unsigned W       = 32;
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t              state_q, state_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic [2*W-1:0]      pend_q, pend_nxt;
   logic [W-1:0]        hi_q, hi_nxt;
   logic [W-1:0]        lo_q, lo_nxt;
   logic                busy_q, busy_nxt;

   logic [2*W-1:0]      prod_s, prod_u;
   logic                div_zero, div_ovf;
   logic signed [W-1:0] rs_s, div_s;
   logic [W-1:0]        div_u;
   logic [2*W-1:0]      div_res_s, div_res_u;

   // Operand arithmetic; divisor forced to 1 on special cases so the divider never sees /0 or overflow
   always_comb begin
      prod_s    = {{W{md.rs_data[W-1]}}, md.rs_data} * {{W{md.rt_data[W-1]}}, md.rt_data};
      prod_u    = {{W{1'b0}}, md.rs_data} * {{W{1'b0}}, md.rt_data};
      div_zero  = (md.rt_data == '0);
      div_ovf   = (md.rs_data == 32'h8000_0000) && (md.rt_data == 32'hFFFF_FFFF);
      rs_s      = $signed(md.rs_data);
      div_s     = (div_zero || div_ovf) ? 32'sd1 : $signed(md.rt_data);
      div_u     = div_zero ? 32'd1 : md.rt_data;
      div_res_u = div_zero ? {md.rs_data, 32'hFFFF_FFFF}
                           : {md.rs_data % div_u, md.rs_data / div_u};
      if (div_zero)
         div_res_s = {md.rs_data, 32'hFFFF_FFFF};
      else if (div_ovf)
         div_res_s = {32'h0, 32'h8000_0000};
      else
         div_res_s = {W'(rs_s % div_s), W'(rs_s / div_s)};
   end

   // Next-state, counter, pending and HI/LO update logic
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      pend_nxt  = pend_q;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      busy_nxt  = busy_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  OP_MULT, OP_MULTU: begin
                     pend_nxt  = (md.op == OP_MULT) ? prod_s : prod_u;
                     cnt_nxt   = CNT_W'(MULT_CYCLES);
                     busy_nxt  = 1'b1;
                     state_nxt = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_nxt  = (md.op == OP_DIV) ? div_res_s : div_res_u;
                     cnt_nxt   = CNT_W'(DIV_CYCLES);
                     busy_nxt  = 1'b1;
                     state_nxt = DIV;
                  end
                  OP_MTHI: hi_nxt = md.rs_data;
                  OP_MTLO: lo_nxt = md.rs_data;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (cnt_q <= CNT_W'(1)) begin
               {hi_nxt, lo_nxt} = pend_q;
               cnt_nxt          = '0;
               busy_nxt         = 1'b0;
               state_nxt        = IDLE;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         pend_q  <= pend_nxt;
         hi_q    <= hi_nxt;
         lo_q    <= lo_nxt;
         busy_q  <= busy_nxt;
      end
   end

   assign md.busy = busy_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule
